// File: rtl/des_key_pkg.sv
// Shared constants, FSM state type and rotate helpers for the DES key schedule.
package des_key_pkg;

    localparam int KEY_W    = 56;
    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;

    // Left-rotate amount per DES round; entry 0 is round 1.
    localparam logic [1:0] SHIFT_TAB [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_t;

    // Total left rotation after 'rounds' rounds, reduced modulo the half width.
    function automatic logic [4:0] cum_shift(input int rounds);
        int total;
        total = 0;
        for (int i = 0; i < rounds; i++) begin
            total += int'(SHIFT_TAB[i[3:0]]);
        end
        return 5'(total % HALF_W);
    endfunction

    // Rotate one 28-bit half left by n (n in 0..27).
    function automatic logic [HALF_W-1:0] rotl_half(input logic [HALF_W-1:0] x,
                                                     input logic [4:0]        n);
        logic [2*HALF_W-1:0] dbl;
        dbl = {x, x} << n;
        return dbl[2*HALF_W-1:HALF_W];
    endfunction

    // Rotate C and D halves independently by the same amount.
    function automatic logic [KEY_W-1:0] rotl_cd(input logic [KEY_W-1:0] cd,
                                                 input logic [4:0]       n);
        return {rotl_half(cd[KEY_W-1:HALF_W], n), rotl_half(cd[HALF_W-1:0], n)};
    endfunction

endpackage

// File: rtl/p_box_56_48.sv
// PC-2 compression permutation: 56-bit CD register to 48-bit round key.
module p_box_56_48
    import des_key_pkg::*;
(
    input  logic [KEY_W-1:0]    cd,
    output logic [SUBKEY_W-1:0] subkey
);

    // Standard PC-2 table, 1-based bit positions counted from the MSB.
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    genvar gi;
    generate
        for (gi = 0; gi < SUBKEY_W; gi++) begin : g_pc2
            assign subkey[SUBKEY_W-1-gi] = cd[KEY_W-PC2_TAB[gi]];
        end
    endgenerate

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential DES key schedule: loads a post-PC-1 key and streams round keys
// over a valid/ready handshake. Define KEY_SCHED_DECRYPT_EN to add decrypt
// (reverse) order; without it mode_i is ignored and only encrypt order exists.
// rk_idx_o is 4 bits wide, so round 16 is presented as 4'h0.
module key_schedule_seq
    import des_key_pkg::*;
#(
    parameter int NUM_ROUNDS  = 16,
    parameter int START_ROUND = 1
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid_i,
    output logic                key_ready_o,
    input  logic [KEY_W-1:0]    key_i,
    input  logic                mode_i,
    output logic                rk_valid_o,
    input  logic                rk_ready_i,
    output logic [SUBKEY_W-1:0] rk_o,
    output logic [3:0]          rk_idx_o,
    output logic                rk_last_o
);

    generate
        if (NUM_ROUNDS < 1 || NUM_ROUNDS > 16 || START_ROUND < 1 ||
            START_ROUND + NUM_ROUNDS - 1 > 16) begin : g_bad_range
            $error("key_schedule_seq: NUM_ROUNDS/START_ROUND out of range");
        end
`ifdef KEY_SCHED_DECRYPT_EN
        if (NUM_ROUNDS != 16 || START_ROUND != 1) begin : g_bad_decrypt
            $error("key_schedule_seq: decrypt support needs NUM_ROUNDS=16, START_ROUND=1");
        end
`endif
    endgenerate

    // The CD register always holds the rotated value whose PC-2 is on rk_o,
    // so the load pre-rotates through the first emitted round.
    localparam logic [4:0] LOAD_ROT    = cum_shift(START_ROUND);
    localparam logic [4:0] FIRST_ROUND = 5'(START_ROUND);
    localparam logic [3:0] LAST_CNT    = 4'(NUM_ROUNDS - 1);

    ks_state_t         state_reg, state_next;
    logic [KEY_W-1:0]  cd_reg, cd_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [4:0]        round_reg, round_next;
    logic              load, handshake, last_key;

`ifdef KEY_SCHED_DECRYPT_EN
    logic              mode_reg, mode_next;
`else
    logic              unused_mode;
    assign unused_mode = mode_i;
`endif

    assign last_key = (cnt_reg == LAST_CNT);
    assign rk_idx_o = round_reg[3:0];

    // Next-state and handshake outputs; outputs depend on state only.
    always_comb begin
        state_next  = state_reg;
        key_ready_o = 1'b0;
        rk_valid_o  = 1'b0;
        rk_last_o   = 1'b0;
        load        = 1'b0;
        handshake   = 1'b0;
        case (state_reg)
            IDLE: begin
                key_ready_o = 1'b1;
                if (key_valid_i) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                rk_valid_o = 1'b1;
                rk_last_o  = last_key;
                if (rk_ready_i) begin
                    handshake = 1'b1;
                    if (last_key) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values: load the key, or step one round per accepted key.
    // The final handshake leaves everything in place so the counter stops at
    // NUM_ROUNDS-1.
    always_comb begin
        cd_next    = cd_reg;
        cnt_next   = cnt_reg;
        round_next = round_reg;
`ifdef KEY_SCHED_DECRYPT_EN
        mode_next  = mode_reg;
`endif
        if (load) begin
            cnt_next = 4'd0;
`ifdef KEY_SCHED_DECRYPT_EN
            mode_next = mode_i;
            if (mode_i) begin
                // Total rotation over 16 rounds is 28, so CD16 equals CD0.
                cd_next    = key_i;
                round_next = 5'd16;
            end else
`endif
            begin
                cd_next    = rotl_cd(key_i, LOAD_ROT);
                round_next = FIRST_ROUND;
            end
        end else if (handshake && !last_key) begin
            cnt_next = cnt_reg + 4'd1;
`ifdef KEY_SCHED_DECRYPT_EN
            if (mode_reg) begin
                // Right rotate by shift[current round] as a left rotate by 28-n.
                cd_next    = rotl_cd(cd_reg, 5'd28 - {3'b000, SHIFT_TAB[4'(round_reg - 5'd1)]});
                round_next = round_reg - 5'd1;
            end else
`endif
            begin
                // Table index equals the 1-based number of the next round minus one.
                cd_next    = rotl_cd(cd_reg, {3'b000, SHIFT_TAB[round_reg[3:0]]});
                round_next = round_reg + 5'd1;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cd_reg    <= '0;
            cnt_reg   <= '0;
            round_reg <= '0;
        end else begin
            state_reg <= state_next;
            cd_reg    <= cd_next;
            cnt_reg   <= cnt_next;
            round_reg <= round_next;
        end
    end

`ifdef KEY_SCHED_DECRYPT_EN
    // Key-order mode captured at load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_reg <= 1'b0;
        end else begin
            mode_reg <= mode_next;
        end
    end
`endif

    p_box_56_48 u_pc2 (
        .cd     (cd_reg),
        .subkey (rk_o)
    );

endmodule

// File: tb/tb_key_schedule_seq.sv
// Self-checking bench for key_schedule_seq (default parameters).
module tb_key_schedule_seq;

    localparam int NR = 16;
    localparam int SR = 1;
    localparam logic [55:0] KAT_KEY = 56'hF0CCAAF556678F;

    logic        clk = 1'b0;
    logic        rst_n, key_valid_i, key_ready_o, mode_i;
    logic        rk_valid_o, rk_ready_i, rk_last_o;
    logic [55:0] key_i;
    logic [47:0] rk_o;
    logic [3:0]  rk_idx_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_schedule_seq #(.NUM_ROUNDS(NR), .START_ROUND(SR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid_i (key_valid_i),
        .key_ready_o (key_ready_o),
        .key_i       (key_i),
        .mode_i      (mode_i),
        .rk_valid_o  (rk_valid_o),
        .rk_ready_i  (rk_ready_i),
        .rk_o        (rk_o),
        .rk_idx_o    (rk_idx_o),
        .rk_last_o   (rk_last_o)
    );

`ifndef KEY_SCHED_DECRYPT_EN
    // Single-key configuration emitting only round 16.
    logic        s_key_valid, s_key_ready, s_rk_valid, s_rk_ready, s_rk_last;
    logic [47:0] s_rk;
    logic [3:0]  s_idx;
    key_schedule_seq #(.NUM_ROUNDS(1), .START_ROUND(16)) dut_single (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid_i (s_key_valid),
        .key_ready_o (s_key_ready),
        .key_i       (KAT_KEY),
        .mode_i      (1'b0),
        .rk_valid_o  (s_rk_valid),
        .rk_ready_i  (s_rk_ready),
        .rk_o        (s_rk),
        .rk_idx_o    (s_idx),
        .rk_last_o   (s_rk_last)
    );
`endif

    // Reference model: DES round keys from cumulative rotation of the halves.
    int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic [47:0] model_ks     [1:16];
    int          exp_round    [0:15];
    logic [47:0] got_by_round [1:16];

    function automatic logic [27:0] rot28(input logic [27:0] x, input int s);
        return (x << s) | (x >> (28 - s));
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_T[i]];
        return r;
    endfunction

    task automatic build_model(input logic [55:0] key, input logic mode);
        int total;
        bit dec;
        total = 0;
        for (int r = 1; r <= 16; r++) begin
            total = (total + SHIFTS[r-1]) % 28;
            model_ks[r] = pc2({rot28(key[55:28], total), rot28(key[27:0], total)});
        end
        dec = 1'b0;
`ifdef KEY_SCHED_DECRYPT_EN
        dec = mode;
`endif
        for (int k = 0; k < NR; k++) exp_round[k] = dec ? (16 - k) : (SR + k);
        if (mode === 1'bx) $display("note: mode unknown");
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] rand_key();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[55:0];
    endfunction

    // Load (optionally) and consume one key sequence, checking every cycle.
    task automatic run_seq(input logic [55:0] key, input logic mode, input int stall_pct,
                           input int noise_pct, input int abort_after, input bit skip_load,
                           input bit hold_next, input logic [55:0] next_key);
        int k;
        int guard;
        build_model(key, mode);
        if (!skip_load) begin
            guard = 0;
            while (key_ready_o !== 1'b1 && guard < 50) begin
                tick();
                guard++;
            end
            check("load_ready", {63'd0, key_ready_o}, 64'd1);
            key_valid_i = 1'b1;
            key_i       = key;
            mode_i      = mode;
            tick();
            key_valid_i = 1'b0;
            key_i       = rand_key();
            mode_i      = 1'($urandom_range(1));
        end
        k = 0;
        guard = 0;
        while (k < NR) begin
            if (guard > 400) begin
                checks++;
                errors++;
                $display("FAIL emit_timeout: got %0d keys expected %0d", k, NR);
                return;
            end
            check("rk_valid", {63'd0, rk_valid_o}, 64'd1);
            check("key_ready_run", {63'd0, key_ready_o}, 64'd0);
            check("rk", {16'd0, rk_o}, {16'd0, model_ks[exp_round[k]]});
            check("rk_idx", {60'd0, rk_idx_o}, {60'd0, 4'(exp_round[k])});
            check("rk_last", {63'd0, rk_last_o}, {63'd0, (k == NR - 1)});
            if (abort_after > 0 && k == abort_after) return;
            rk_ready_i  = ($urandom_range(99) >= stall_pct);
            key_valid_i = ($urandom_range(99) < noise_pct);
            key_i       = rand_key();
            if (hold_next && k == NR - 1 && rk_ready_i) begin
                key_valid_i = 1'b1;
                key_i       = next_key;
                mode_i      = 1'b0;
            end
            if (rk_ready_i) begin
                got_by_round[exp_round[k]] = rk_o;
                $display("key %h mode %0b k=%0d round=%0d rk=%h idx=%0d last=%0b",
                         key, mode, k, exp_round[k], rk_o, rk_idx_o, rk_last_o);
            end
            tick();
            guard++;
            if (rk_ready_i) k++;
        end
        if (!hold_next) key_valid_i = 1'b0;
        check("end_key_ready", {63'd0, key_ready_o}, 64'd1);
        check("end_rk_valid", {63'd0, rk_valid_o}, 64'd0);
    endtask

    typedef struct {
        logic [55:0] key;
        logic        mode;
        int          stall_pct;
        int          round;
        logic [47:0] exp_rk;
    } kat_t;

    kat_t kat [7];

    initial begin
        kat[0] = '{KAT_KEY, 1'b0,  0,  1, 48'h1B02EFFC7072};
        kat[1] = '{KAT_KEY, 1'b0,  0,  2, 48'h79AED9DBC9E5};
        kat[2] = '{KAT_KEY, 1'b0,  0, 16, 48'hCB3D8B0E17F5};
        kat[3] = '{KAT_KEY, 1'b1,  0, 16, 48'hCB3D8B0E17F5};
        kat[4] = '{KAT_KEY, 1'b1,  0,  1, 48'h1B02EFFC7072};
        kat[5] = '{KAT_KEY, 1'b0, 50,  1, 48'h1B02EFFC7072};
        kat[6] = '{KAT_KEY, 1'b0, 50, 16, 48'hCB3D8B0E17F5};

        rst_n = 1'b0; key_valid_i = 1'b0; key_i = '0; mode_i = 1'b0; rk_ready_i = 1'b0;
`ifndef KEY_SCHED_DECRYPT_EN
        s_key_valid = 1'b0; s_rk_ready = 1'b0;
`endif
        tick();
        tick();
        check("rst_key_ready", {63'd0, key_ready_o}, 64'd1);
        check("rst_rk_valid", {63'd0, rk_valid_o}, 64'd0);
        check("rst_rk_last", {63'd0, rk_last_o}, 64'd0);
        check("rst_rk", {16'd0, rk_o}, 64'd0);
        check("rst_rk_idx", {60'd0, rk_idx_o}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Known-answer table.
        for (int i = 0; i < 7; i++) begin
            run_seq(kat[i].key, kat[i].mode, kat[i].stall_pct, 0, 0, 1'b0, 1'b0, '0);
            check($sformatf("kat%0d_round%0d", i, kat[i].round),
                  {16'd0, got_by_round[kat[i].round]}, {16'd0, kat[i].exp_rk});
        end

`ifdef KEY_SCHED_DECRYPT_EN
        // Decrypt order: first key is round 16, last is round 1.
        run_seq(KAT_KEY, 1'b1, 0, 0, 0, 1'b0, 1'b0, '0);
        check("dec_first_is_k16", {16'd0, got_by_round[16]}, {16'd0, 48'hCB3D8B0E17F5});
`endif

        // Randomized keys, modes, stalls and ignored load requests.
        for (int i = 0; i < 20; i++) begin
            run_seq(rand_key(), 1'($urandom_range(1)), 30, 30, 0, 1'b0, 1'b0, '0);
        end

        // Reset after the 5th key aborts the sequence; reload restarts at K1.
        run_seq(KAT_KEY, 1'b0, 20, 0, 5, 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        rk_ready_i = 1'b1;
        tick();
        rst_n = 1'b1;
        check("abort_key_ready", {63'd0, key_ready_o}, 64'd1);
        check("abort_rk_valid", {63'd0, rk_valid_o}, 64'd0);
        check("abort_rk_idx", {60'd0, rk_idx_o}, 64'd0);
        tick();
        check("abort_still_idle", {63'd0, rk_valid_o}, 64'd0);
        run_seq(KAT_KEY, 1'b0, 0, 0, 0, 1'b0, 1'b0, '0);

        // key_valid held through the last handshake: loads one cycle later.
        run_seq(rand_key(), 1'b0, 20, 0, 0, 1'b0, 1'b1, KAT_KEY);
        tick();
        key_valid_i = 1'b0;
        run_seq(KAT_KEY, 1'b0, 0, 0, 0, 1'b1, 1'b0, '0);
        check("reload_k1", {16'd0, got_by_round[1]}, {16'd0, 48'h1B02EFFC7072});

`ifndef KEY_SCHED_DECRYPT_EN
        // NUM_ROUNDS=1, START_ROUND=16 emits a single K16 flagged last.
        check("single_ready", {63'd0, s_key_ready}, 64'd1);
        s_key_valid = 1'b1;
        tick();
        s_key_valid = 1'b0;
        s_rk_ready  = 1'b1;
        check("single_valid", {63'd0, s_rk_valid}, 64'd1);
        check("single_rk", {16'd0, s_rk}, {16'd0, 48'hCB3D8B0E17F5});
        check("single_idx", {60'd0, s_idx}, 64'd0);
        check("single_last", {63'd0, s_rk_last}, 64'd1);
        $display("single key rk=%h idx=%0d last=%0b", s_rk, s_idx, s_rk_last);
        tick();
        check("single_done", {63'd0, s_key_ready}, 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_schedule_seq.md
KEY_SCHEDULE_SEQ -- requirements
Module: key_schedule_seq

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 16, meaning number of round keys emitted per key load; legal range 1..16.
REQ-002 SHALL have parameter START_ROUND, default 1, meaning 1-based DES round of the first encrypt-order key; START_ROUND+NUM_ROUNDS-1 <= 16, else elaboration error.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port key_valid_i  input  1  load request.
REQ-007 SHALL have port key_ready_o  output  1  block can accept a load.
REQ-008 SHALL have port key_i  input  56  post-PC-1 key; C half is [55:28], D half is [27:0].
REQ-009 SHALL have port mode_i  input  1  0 encrypt order, 1 decrypt order; sampled at load.
REQ-010 SHALL have port rk_valid_o  output  1  round key valid.
REQ-011 SHALL have port rk_ready_i  input  1  consumer accepts round key.
REQ-012 SHALL have port rk_o  output  48  PC-2 round key.
REQ-013 SHALL have port rk_idx_o  output  4  DES round number (1..16) of rk_o.
REQ-014 SHALL have port rk_last_o  output  1  final key of the sequence.

Function
REQ-015 SHALL have FSM states IDLE and RUN.
REQ-016 IDLE: key_ready_o=1, rk_valid_o=0; key_valid_i=1 latches key_i and mode_i into the CD register, clears the emit counter, and moves to RUN.
REQ-017 In RUN, rk_valid_o SHALL be 1 from the cycle after load; first key is valid one cycle after acceptance.
REQ-018 In RUN, key_ready_o SHALL be 0; key_valid_i is ignored.
REQ-019 Round key handshake occurs when rk_valid_o and rk_ready_i are both 1; on handshake CD, counter and rk_idx_o advance.
REQ-020 When rk_ready_i=0, rk_o, rk_idx_o and rk_last_o SHALL hold stable.
REQ-021 Encrypt: rotate C and D left independently by shift[r], r = START_ROUND+k; rk_o = PC-2(rotated CD); rk_idx_o = r.
REQ-022 Encrypt with START_ROUND>1: at load, CD SHALL be pre-rotated by the sum of shift[1..START_ROUND-1].
REQ-023 Shift table by round 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-024 Decrypt (with REQ-036): emit k=0: rk_o = PC-2(CD unrotated), rk_idx_o=16; emit k>=1: rotate right by shift[17-k], rk_idx_o=16-k.
REQ-025 rk_last_o SHALL be 1 only on the NUM_ROUNDS-th key.
REQ-026 Handshake on the last key SHALL return the FSM to IDLE; key_ready_o is 1 the following cycle, with no same-cycle reload.
REQ-027 Rotations SHALL be modulo 28 per half; a 4-bit counter never exceeds NUM_ROUNDS-1.
REQ-028 Combinational path key_valid_i -> key_ready_o or rk_ready_i -> rk_valid_o SHALL NOT exist.

Reset
REQ-029 rst_n=0 at a clk edge SHALL force IDLE, CD=0, counter=0, mode=0.
REQ-030 Reset outputs: key_ready_o=1, rk_valid_o=0, rk_last_o=0, rk_o=PC-2(0)=0, rk_idx_o=0.
REQ-031 Reset in RUN SHALL abort the sequence with no further keys emitted.

Configuration
REQ-032 Macro KEY_SCHED_DECRYPT_EN SHALL control decrypt support.
REQ-033 With KEY_SCHED_DECRYPT_EN defined, mode_i=1 follows REQ-024.
REQ-034 With KEY_SCHED_DECRYPT_EN defined, parameters other than NUM_ROUNDS=16 and START_ROUND=1 SHALL be an elaboration error.
REQ-035 With KEY_SCHED_DECRYPT_EN undefined, mode_i SHALL be ignored, encrypt order is always used, and no right-rotate logic is built.

Structure
REQ-036 Package des_key_pkg SHALL hold KEY_W=56, HALF_W=28, SUBKEY_W=48, the 16-entry shift table, the FSM state enum, and a cumulative-shift function.
REQ-037 Sub-module p_box_56_48 (existing PC-2) SHALL be instantiated once on the rotated CD.

Verification
REQ-038 Load key_i=F0CCAAF556678F, mode 0, rk_ready_i=1 -> keys on 16 consecutive cycles; K1=1B02EFFC7072, K2=79AED9DBC9E5, K16=CB3D8B0E17F5 with rk_last_o.
REQ-039 Same key, mode 1, macro defined -> first rk_o=CB3D8B0E17F5 with idx 16; last rk_o=1B02EFFC7072 with idx 1 and rk_last_o=1.
REQ-040 REQ-038 stimulus with rk_ready_i toggling randomly -> identical key sequence, outputs stable during stall, and key_valid_i pulses in RUN ignored.
REQ-041 NUM_ROUNDS=2, START_ROUND=16 -> error at elaboration; NUM_ROUNDS=1, START_ROUND=16 -> single key CB3D8B0E17F5 with rk_last_o=1.
REQ-042 rst_n=0 after the 5th key -> next cycle key_ready_o=1 and rk_valid_o=0; reload restarts at K1.
REQ-043 Last-key handshake with key_valid_i held high -> no load that cycle, load accepted the next cycle, and K1 valid one cycle later.
